// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: FSM state encoding and baseband symbol constants.
// Used by the symbol mapper and the digital up-converter so both agree on
// the signed antipodal symbol levels for a given baseband width.
package bpsk_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Widest baseband supported by the constant helpers below.
    localparam int unsigned SYM_MAX_W = 32;

    // Idle level is zero at any width.
    localparam logic [SYM_MAX_W-1:0] SYM_ZERO = '0;

    // Low 'bwidth' bits set.
    function automatic logic [SYM_MAX_W-1:0] width_mask(input int unsigned bwidth);
        logic [SYM_MAX_W-1:0] ones;
        ones = '1;
        return ones >> (SYM_MAX_W - bwidth);
    endfunction

    // +1 : value 1 zero-extended to bwidth.
    function automatic logic [SYM_MAX_W-1:0] sym_pos(input int unsigned bwidth);
        return SYM_MAX_W'(1) & width_mask(bwidth);
    endfunction

    // -1 : all ones at bwidth.
    function automatic logic [SYM_MAX_W-1:0] sym_neg(input int unsigned bwidth);
        return width_mask(bwidth);
    endfunction

endpackage

// File: rtl/bpsk_symbol_mapper_sym_counter.sv
// Mod-SPS sample counter with load-zero, increment and terminal-count output.
module sym_counter #(
    parameter  int SPS   = 16,
    localparam int CNT_W = $clog2(SPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_zero,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == CNT_W'(SPS - 1));

    // Load-zero has priority; increment never runs past SPS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_zero) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bpsk_symbol_mapper.sv
// BPSK symbol mapper: takes a serial bit stream over valid/ready, maps each bit
// to a signed antipodal symbol and holds it for SPS sample cycles.
// Optional differential encoding is enabled by defining BPSK_DIFF_ENC_EN.
module bpsk_symbol_mapper
    import bpsk_pkg::*;
#(
    parameter int BWIDTH = 2,
    parameter int SPS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_data,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [BWIDTH-1:0] base_sig,
    output logic              sym_valid,
    output logic              sym_start,
    output logic              underrun
);

    localparam int CNT_W = $clog2(SPS);

    localparam logic [SYM_MAX_W-1:0] POS_FULL  = sym_pos(BWIDTH);
    localparam logic [SYM_MAX_W-1:0] NEG_FULL  = sym_neg(BWIDTH);
    localparam logic [BWIDTH-1:0]    SYM_POS_W = POS_FULL[BWIDTH-1:0];
    localparam logic [BWIDTH-1:0]    SYM_NEG_W = NEG_FULL[BWIDTH-1:0];
    localparam logic [BWIDTH-1:0]    SYM_ZERO_W = SYM_ZERO[BWIDTH-1:0];

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic              tc;
    logic              sym_end;
    logic              transfer;
    logic              mapped;
    logic [BWIDTH-1:0] new_sym;
    logic              cnt_load;
    logic              cnt_inc;
    logic [BWIDTH-1:0] base_d;
    logic              sym_valid_d;
    logic              sym_start_d;
    logic              underrun_d;

    sym_counter #(
        .SPS (SPS)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_zero (cnt_load),
        .inc       (cnt_inc),
        .cnt       (cnt),
        .tc        (tc)
    );

    assign sym_end   = (state_q == ACTIVE) && tc;
    assign bit_ready = (state_q == IDLE) || sym_end;
    assign transfer  = bit_valid && bit_ready;

`ifdef BPSK_DIFF_ENC_EN
    logic d_prev;

    assign mapped = bit_data ^ d_prev;

    // Differential reference: follows each transferred symbol, restarts at 0 per burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev <= 1'b0;
        end else if (transfer) begin
            d_prev <= mapped;
        end else if (state_q == ACTIVE && state_d == IDLE) begin
            d_prev <= 1'b0;
        end
    end
`else
    assign mapped = bit_data;
`endif

    assign new_sym = mapped ? SYM_NEG_W : SYM_POS_W;

    // Next-state and next-output decode; pulses default low.
    always_comb begin
        state_d     = state_q;
        base_d      = base_sig;
        sym_valid_d = sym_valid;
        sym_start_d = 1'b0;
        underrun_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d     = ACTIVE;
                    cnt_load    = 1'b1;
                    base_d      = new_sym;
                    sym_valid_d = 1'b1;
                    sym_start_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (!tc) begin
                    cnt_inc = 1'b1;
                end else if (transfer) begin
                    cnt_load    = 1'b1;
                    base_d      = new_sym;
                    sym_start_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    cnt_load    = 1'b1;
                    base_d      = SYM_ZERO_W;
                    sym_valid_d = 1'b0;
                    underrun_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_sig  <= '0;
            sym_valid <= 1'b0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_sig  <= base_d;
            sym_valid <= sym_valid_d;
            sym_start <= sym_start_d;
            underrun  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// Directed bench for bpsk_symbol_mapper with an expected-symbol scoreboard.
// Honours BPSK_DIFF_ENC_EN when defined.
module tb_bpsk_symbol_mapper;

    localparam int BW  = 2;
    localparam int SPS = 16;

    logic          clk;
    logic          rst_n;
    logic          bit_data;
    logic          bit_valid;
    logic          bit_ready;
    logic [BW-1:0] base_sig;
    logic          sym_valid;
    logic          sym_start;
    logic          underrun;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] exp_q[$];
    logic          model_dprev = 1'b0;

    bpsk_symbol_mapper #(
        .BWIDTH (BW),
        .SPS    (SPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_data  (bit_data),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .base_sig  (base_sig),
        .sym_valid (sym_valid),
        .sym_start (sym_start),
        .underrun  (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a bit and record the symbol it must produce.
    task automatic push_bit(input logic b);
        logic m;
`ifdef BPSK_DIFF_ENC_EN
        m = b ^ model_dprev;
        model_dprev = m;
`else
        m = b;
`endif
        bit_valid = 1'b1;
        bit_data  = b;
        exp_q.push_back(m ? 2'b11 : 2'b01);
    endtask

    // Called just after the transfer edge; checks all SPS samples of the symbol.
    // Optionally offers the next bit when the sample index reaches raise_at.
    task automatic run_symbol(input int raise_at, input logic nxt_valid, input logic nxt_data);
        logic [BW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        for (int k = 0; k < SPS; k++) begin
            chk("base_sig", 32'(base_sig), 32'(e));
            chk("sym_valid", 32'(sym_valid), 32'd1);
            chk("sym_start", 32'(sym_start), (k == 0) ? 32'd1 : 32'd0);
            chk("bit_ready", 32'(bit_ready), (k == SPS - 1) ? 32'd1 : 32'd0);
            chk("underrun_mid", 32'(underrun), 32'd0);
            if (k == 0) bit_valid = 1'b0;
            if (k == raise_at && nxt_valid) push_bit(nxt_data);
            if (k < SPS - 1) tick();
        end
    endtask

    // Called just after the edge that ends a symbol with no follow-on bit.
    task automatic idle_check();
        chk("idle_base", 32'(base_sig), 32'd0);
        chk("idle_valid", 32'(sym_valid), 32'd0);
        chk("idle_start", 32'(sym_start), 32'd0);
        chk("underrun_pulse", 32'(underrun), 32'd1);
        chk("idle_ready", 32'(bit_ready), 32'd1);
        model_dprev = 1'b0;
        tick();
        chk("underrun_clear", 32'(underrun), 32'd0);
        chk("idle_base2", 32'(base_sig), 32'd0);
        chk("idle_valid2", 32'(sym_valid), 32'd0);
    endtask

    initial begin
        logic [BW-1:0] e;

        // Reset values
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        #12;
        chk("rst_base", 32'(base_sig), 32'd0);
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_start", 32'(sym_start), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(bit_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single bit 0, accepted on the first edge
        push_bit(1'b0);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();

        // Back-to-back bits 0,1,0
        push_bit(1'b0);
        tick();
        run_symbol(0, 1'b1, 1'b1);
        tick();
        run_symbol(0, 1'b1, 1'b0);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();

        // Single bit 1 then starvation
        push_bit(1'b1);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();

        // Bit offered mid-symbol waits for the terminal sample
        push_bit(1'b0);
        tick();
        run_symbol(5, 1'b1, 1'b1);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();

        // Reset asserted mid-symbol at cnt = 7
        push_bit(1'b1);
        tick();
        bit_valid = 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        for (int k = 0; k < 7; k++) begin
            chk("pre_rst_base", 32'(base_sig), 32'(e));
            tick();
        end
        chk("pre_rst_base7", 32'(base_sig), 32'(e));
        bit_valid = 1'b1;
        bit_data  = 1'b0;
        rst_n     = 1'b0;
        model_dprev = 1'b0;
        #1;
        chk("async_base", 32'(base_sig), 32'd0);
        chk("async_valid", 32'(sym_valid), 32'd0);
        chk("async_ready", 32'(bit_ready), 32'd1);
        tick();
        chk("rst_hold_base", 32'(base_sig), 32'd0);
        chk("rst_hold_valid", 32'(sym_valid), 32'd0);
        chk("rst_hold_start", 32'(sym_start), 32'd0);
        rst_n = 1'b1;
        push_bit(1'b0);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();

`ifdef BPSK_DIFF_ENC_EN
        // Differential burst 1,1,0,1 -> 11,01,01,11
        push_bit(1'b1);
        tick();
        run_symbol(0, 1'b1, 1'b1);
        tick();
        run_symbol(0, 1'b1, 1'b0);
        tick();
        run_symbol(0, 1'b1, 1'b1);
        tick();
        run_symbol(SPS, 1'b0, 1'b0);
        tick();
        idle_check();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
